// File: rtl/cmp_seq_ctrl_if.sv
// Handshake and result bundle for cmp_seq_ctrl.
// The master side is the producer/consumer. The slave side is the sequencer.
interface cmp_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*WORDS-1:0]   a;
    logic [WIDTH*WORDS-1:0]   b;
    logic                     out_valid;
    logic                     out_ready;
    logic                     agtb;
    logic                     altb;
    logic                     aeqb;
    logic [$clog2(WORDS):0]   words_used;
    logic                     busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, agtb, altb, aeqb, words_used, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, agtb, altb, aeqb, words_used, busy
    );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: walks one WIDTH-bit comparator over WORDS words, MSW first,
// and stops at the first word that differs. The result is a registered,
// one-hot gt/lt/eq flag.
// Optional build macro CMP_SEQ_SIGNED_EN: the MSW is compared as two's
// complement. Lower words are always compared unsigned.
module cmp_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    cmp_seq_ctrl_if.slave bus
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNTW = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t                       state_q, state_d;
    logic [WORDS-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [IDXW-1:0]              idx_q, idx_d;
    logic [CNTW-1:0]              cnt_q, cnt_d;
    logic                         agtb_q, agtb_d, altb_q, altb_d, aeqb_q, aeqb_d;

    logic [WIDTH-1:0]             wa, wb;
    logic                         wlt;

    assign wa = a_q[idx_q];
    assign wb = b_q[idx_q];

`ifdef CMP_SEQ_SIGNED_EN
    // The sign bit lives only in the MSW, which is always the first word compared.
    logic msw;
    assign msw = (idx_q == IDXW'(WORDS-1));
    assign wlt = msw ? ($signed(wa) < $signed(wb)) : (wa < wb);
`else
    assign wlt = (wa < wb);
`endif

    // State and datapath registers. Reset discards any compare in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            agtb_q  <= 1'b0;
            altb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            agtb_q  <= agtb_d;
            altb_q  <= altb_d;
            aeqb_q  <= aeqb_d;
        end
    end

    // Next state: capture in IDLE, compare one word per CMP cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        agtb_d  = agtb_q;
        altb_d  = altb_q;
        aeqb_d  = aeqb_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = IDXW'(WORDS-1);
                    cnt_d   = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                cnt_d = cnt_q + CNTW'(1);
                if (wa != wb) begin
                    altb_d  = wlt;
                    agtb_d  = !wlt;
                    aeqb_d  = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    altb_d  = 1'b0;
                    agtb_d  = 1'b0;
                    aeqb_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.agtb       = agtb_q;
    assign bus.altb       = altb_q;
    assign bus.aeqb       = aeqb_q;
    assign bus.words_used = cnt_q;
endmodule
